// File: rtl/mips_cache_pkg.sv
// mips_cache_pkg: FSM state encoding, address-field width helpers and line word-slice helper
package mips_cache_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  localparam int MAX_LINE_W = 1024;
  function automatic int off_w(int line_words);
    return $clog2(line_words) + 2;
  endfunction
  function automatic int idx_w(int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_w(int addr_w, int line_words, int num_lines);
    return addr_w - off_w(line_words) - idx_w(num_lines);
  endfunction
  function automatic logic [MAX_LINE_W-1:0] line_word(logic [MAX_LINE_W-1:0] line, int w, int data_w);
    return line >> (w * data_w);
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: valid/dirty/tag/data arrays, async read, word-write and line-write ports
module cache_line_store #(
  parameter int DATA_W = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 22,
  parameter int WORD_W = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IDX_W-1:0]             idx,
  output logic                         rvalid,
  output logic                         rdirty,
  output logic [TAG_W-1:0]             rtag,
  output logic [LINE_WORDS*DATA_W-1:0] rline,
  input  logic                         word_we,
  input  logic [WORD_W-1:0]            word_sel,
  input  logic [DATA_W-1:0]            word_data,
  input  logic                         line_we,
  input  logic [TAG_W-1:0]             line_tag,
  input  logic [LINE_WORDS*DATA_W-1:0] line_data
);
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [NUM_LINES];
  logic [LINE_WORDS*DATA_W-1:0] data [NUM_LINES];
  assign rvalid = valid[idx];
  assign rdirty = dirty[idx];
  assign rtag = tags[idx];
  assign rline = data[idx];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we) dirty[idx] <= 1'b1;
  // tag and data contents survive reset; valid alone qualifies them
  always_ff @(posedge clk)
    if (line_we) begin
      tags[idx] <= line_tag;
      data[idx] <= line_data;
    end else if (word_we) data[idx][word_sel*DATA_W +: DATA_W] <= word_data;
endmodule

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped write-back L1 D-cache controller with writeback/refill FSM.
// Define CACHE_STATS_EN to add the stat_hits/stat_misses counters.
module data_cache_ctrl
  import mips_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic                         hit,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_WORDS*DATA_W-1:0] mem_wdata,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_rdata,
  output logic                         mem_read,
  output logic                         mem_write,
`ifdef CACHE_STATS_EN
  output logic [31:0]                  stat_hits,
  output logic [31:0]                  stat_misses,
`endif
  input  logic                         mem_ack
);
  localparam int OFF = off_w(LINE_WORDS);
  localparam int IDX = idx_w(NUM_LINES);
  localparam int TAG = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  state_t state, next;
  logic [OFF-3:0] word;
  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag, rtag;
  logic [LINE_WORDS*DATA_W-1:0] rline;
  logic rvalid, rdirty, req, word_we, line_we;
  assign word = cpu_addr[OFF-1:2];
  assign idx = cpu_addr[OFF+IDX-1:OFF];
  assign tag = cpu_addr[ADDR_W-1:OFF+IDX];
  assign req = cpu_read || cpu_write;
  assign hit = rvalid && rtag == tag;
  assign mem_wdata = rline;
  assign cpu_rdata = DATA_W'(line_word(MAX_LINE_W'(rline), int'(word), DATA_W));
  cache_line_store #(
    .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES),
    .IDX_W(IDX), .TAG_W(TAG), .WORD_W(OFF - 2)
  ) store (
    .clk(clk), .reset(reset), .idx(idx),
    .rvalid(rvalid), .rdirty(rdirty), .rtag(rtag), .rline(rline),
    .word_we(word_we), .word_sel(word), .word_data(cpu_wdata),
    .line_we(line_we), .line_tag(tag), .line_data(mem_rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // a store (alone or with cpu_read) writes only on a hit; misses refill first and then replay
  always_comb begin
    next = state;
    cpu_ready = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_addr = {tag, idx, {OFF{1'b0}}};
    word_we = 1'b0;
    line_we = 1'b0;
    case (state)
      IDLE: begin
        cpu_ready = !req || hit;
        word_we = cpu_write && hit;
        next = (req && !hit) ? ((rvalid && rdirty) ? WB : FILL) : IDLE;
      end
      WB: begin
        mem_write = 1'b1;
        mem_addr = {rtag, idx, {OFF{1'b0}}};
        next = mem_ack ? FILL : WB;
      end
      default: begin
        mem_read = 1'b1;
        line_we = mem_ack;
        next = mem_ack ? IDLE : FILL;
      end
    endcase
  end
`ifdef CACHE_STATS_EN
  logic replay;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_hits <= '0;
      stat_misses <= '0;
      replay <= 1'b0;
    end else begin
      replay <= state == FILL && mem_ack;
      if (state == IDLE && req && hit && !replay) stat_hits <= stat_hits + 32'd1;
      if (state == IDLE && req && !hit) stat_misses <= stat_misses + 32'd1;
    end
`endif
endmodule
